sha256_msg_sched: RTL

SHA-256 message-schedule generator. It accepts one 512-bit padded message block and streams the 64 schedule words W[0..63], one per handshake beat. Its consumer is the compression-round datapath, where the Ch/Maj/Sigma logic lives. A 16-word sliding window holds the block, so no 64-word storage is needed.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_small_sigma.sv | 18 +
 rtl/sha256_msg_sched.sv | 84 ++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, state encoding and rotate helper for the SHA-256 message schedule.
package sha256_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA256_WORD_W = 32;

    // sigma0 = ROTR7 ^ ROTR18 ^ SHR3, sigma1 = ROTR17 ^ ROTR19 ^ SHR10
    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [SHA256_WORD_W-1:0] rotr(input logic [SHA256_WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (SHA256_WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: combinational SHA-256 small-sigma function.
// Ports: i_x word in, o_y sigma(i_x) out. SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter bit SEL = 1'b0
) (
    input  logic [SHA256_WORD_W-1:0] i_x,
    output logic [SHA256_WORD_W-1:0] o_y
);

    localparam int ROT_A = SEL ? S1_ROT_A : S0_ROT_A;
    localparam int ROT_B = SEL ? S1_ROT_B : S0_ROT_B;
    localparam int SHR   = SEL ? S1_SHR   : S0_SHR;

    assign o_y = rotr(i_x, ROT_A) ^ rotr(i_x, ROT_B) ^ (i_x >> SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: streams the 64 SHA-256 schedule words of one 512-bit block through a 16-word window.
// Ports: clk/rst_n (async active-low); blk_valid/blk_ready/blk_data block input handshake;
// w_valid/w_ready/w_data/w_idx/w_last schedule word output handshake.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int WORD_W = SHA256_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [16*WORD_W-1:0] blk_data,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [5:0]           w_idx,
    output logic                 w_last
);

    state_t              r_state;
    state_t              w_next;
    logic [WORD_W-1:0]   r_win [16];
    logic [5:0]          r_idx;
    logic [WORD_W-1:0]   w_s0;
    logic [WORD_W-1:0]   w_s1;
    logic                w_load;
    logic                w_beat;
    logic                w_end;

    sha256_small_sigma #(.SEL(1'b0)) u_s0 (.i_x(r_win[1]),  .o_y(w_s0));
    sha256_small_sigma #(.SEL(1'b1)) u_s1 (.i_x(r_win[14]), .o_y(w_s1));

    // Handshake outputs depend only on the state register, never on blk_valid/w_ready.
    assign blk_ready = (r_state == IDLE);
    assign w_valid   = (r_state == RUN);
    assign w_data    = r_win[0];
    assign w_idx     = r_idx;
    assign w_end     = (r_idx == 6'(ROUNDS - 1));
    assign w_last    = w_valid && w_end;
    assign w_load    = blk_ready && blk_valid;
    assign w_beat    = w_valid && w_ready;

    always_comb begin
        w_next = r_state;
        if (w_load)
            w_next = RUN;
        else if (w_beat && w_end)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= '0;
        else if (w_load)
            r_idx <= '0;
        else if (w_beat)
            r_idx <= r_idx + 6'd1;
    end

    // r_win[i] holds W[t+i]; each beat shifts down and appends W[t+16].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                r_win[i] <= '0;
        end else if (w_load) begin
            for (int i = 0; i < 16; i++)
                r_win[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
        end else if (w_beat) begin
            for (int i = 0; i < 15; i++)
                r_win[i] <= r_win[i+1];
            r_win[15] <= w_s1 + r_win[9] + w_s0 + r_win[0];
        end
    end

endmodule
